// File: rtl/hazard_scoreboard.sv
// Purpose : per-register latency scoreboard and branch interlock driving PC/IF/ID enables and ID/EX bubble insert.
// Latency : all outputs are combinational from the ID/EX/wait inputs and registered state; state updates on the next edge.
// Backpr. : any wait_in bit freezes every count, the FSM and the flush counter; raw/waw hazards hold PC and IF/ID and bubble ID/EX.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid, id_rs, id_rs_used     ID instruction and its source registers (port i at id_rs[5i+4:5i])
//   id_write_reg, id_rd, id_latency destination register and cycles until its result is bypassable
//   id_is_branch                    ID instruction is a branch/jump
//   ex_branch_resolve/_taken        branch outcome from EX
//   wait_in                         freeze requests (imem, dmem, div)
//   pipe_enable, pc_write_enable,
//   ifid_write_enable, id_issue,
//   flush                           pipeline control
//   pending                         bit r set while register r has an outstanding result
module hazard_scoreboard #(
    parameter int NUM_SRC       = 2,
    parameter int NUM_WAIT      = 3,
    parameter int MAX_LAT       = 34,
    parameter int BRANCH_POLICY = 0,
    parameter int FLUSH_CYCLES  = 1,
    parameter int LAT_W         = $clog2(MAX_LAT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [NUM_SRC*5-1:0] id_rs,
    input  logic [NUM_SRC-1:0]   id_rs_used,
    input  logic                 id_write_reg,
    input  logic [4:0]           id_rd,
    input  logic [LAT_W-1:0]     id_latency,
    input  logic                 id_is_branch,
    input  logic                 ex_branch_resolve,
    input  logic                 ex_branch_taken,
    input  logic [NUM_WAIT-1:0]  wait_in,
    output logic                 pipe_enable,
    output logic                 pc_write_enable,
    output logic                 ifid_write_enable,
    output logic                 id_issue,
    output logic                 flush,
    output logic [31:0]          pending
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] fcnt, fcnt_nxt;
    // cnt[0] is only ever written by reset, so it stays constant zero.
    logic [LAT_W-1:0] cnt [32];

    logic raw_stall;
    logic waw_stall;
    logic hazard;
    logic en;
    logic take;

    // Enable is forced low during reset so nothing downstream moves.
    assign en          = rst_n && !(|wait_in);
    assign pipe_enable = en;
    // A taken resolve is only acted on in an enabled cycle.
    assign take        = en && ex_branch_resolve && ex_branch_taken;

    always_comb begin
        raw_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (cnt[id_rs[5*i +: 5]] != '0)) begin
                raw_stall = 1'b1;
            end
        end
        raw_stall = raw_stall && id_valid;
    end

    // A younger writer with a shorter latency must not complete before the older one.
    assign waw_stall = id_valid && id_write_reg && (id_rd != 5'd0) && (cnt[id_rd] > id_latency);
    assign hazard    = raw_stall || waw_stall;

    assign id_issue = en && id_valid && !hazard && (state == ST_RUN)
                      && !(ex_branch_resolve && ex_branch_taken);

    always_comb begin
        state_nxt         = state;
        fcnt_nxt          = fcnt;
        pc_write_enable   = en;
        ifid_write_enable = en;
        flush             = 1'b0;
        if (take) begin
            // Redirect: PC takes the target, IF/ID is cleared, ID/EX gets a bubble.
            state_nxt         = ST_FLUSH;
            fcnt_nxt          = '0;
            pc_write_enable   = 1'b1;
            ifid_write_enable = 1'b1;
            flush             = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        pc_write_enable   = 1'b0;
                        ifid_write_enable = 1'b0;
                        flush             = 1'b1;
                    end
                    if (id_issue && id_is_branch && (BRANCH_POLICY == 0)) begin
                        state_nxt = ST_BR_WAIT;
                    end
                end
                ST_BR_WAIT: begin
                    pc_write_enable   = 1'b0;
                    ifid_write_enable = 1'b0;
                    flush             = 1'b1;
                    // Taken is handled above, so any resolve here is not-taken.
                    if (en && ex_branch_resolve) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush = 1'b1;
                    if (en) begin
                        if (fcnt == FC_LAST) begin
                            state_nxt = ST_RUN;
                            fcnt_nxt  = '0;
                        end else begin
                            fcnt_nxt = fcnt + FC_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = '0;
                end
            endcase
        end
        if (!rst_n) begin
            pc_write_enable   = 1'b0;
            ifid_write_enable = 1'b0;
            flush             = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (en) begin
            for (int r = 1; r < 32; r++) begin
                // A fresh issue to the same register overrides its countdown.
                if (id_issue && id_write_reg && (id_rd == 5'(r))) begin
                    cnt[r] <= id_latency;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = (cnt[r] != '0);
        end
    end

endmodule
